// File: rtl/control_sequencer.sv
// Hardwired three-phase control unit for the ALU_System datapath: two byte fetches
// into the IR, one decode/execute cycle, and a sticky HALT state left only by reset.
module control_sequencer (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic [15:0] IR_Out,
   input  logic [3:0]  ALU_ZCNO,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic [2:0]  RF_OutASel,
   output logic [2:0]  RF_OutBSel,
   output logic [1:0]  RF_FunSel,
   output logic [3:0]  RF_RSel,
   output logic [3:0]  RF_TSel,
   output logic [3:0]  ALU_FunSel,
   output logic [1:0]  ARF_OutASel,
   output logic [1:0]  ARF_OutBSel,
   output logic [1:0]  ARF_FunSel,
   output logic [3:0]  ARF_RSel,
   output logic [1:0]  IR_Funsel,
   output logic        IR_Enable,
   output logic        IR_LH,
   output logic        Mem_WR,
   output logic        Mem_CS,
   output logic        Halted,
   output logic        Illegal
);

   typedef enum logic [1:0] {
      FETCH_L = 2'd0,
      FETCH_H = 2'd1,
      EXEC    = 2'd2,
      HALT    = 2'd3
   } state_t;

   localparam logic [1:0] FUN_INC  = 2'b01;
   localparam logic [1:0] FUN_LOAD = 2'b10;
   localparam logic [1:0] FUN_CLR  = 2'b11;
   localparam logic [3:0] PC_SEL   = 4'b1000;

   state_t     state, state_nxt;
   logic [3:0] opcode;
   logic [1:0] rd, rs;
   logic       flag_z;
   logic       unused_bits;

   assign opcode      = IR_Out[15:12];
   assign rd          = IR_Out[11:10];
   assign rs          = IR_Out[9:8];
   assign flag_z      = ALU_ZCNO[3];
   // The immediate travels to the datapath through the IR itself, not through us.
   assign unused_bits = &{1'b0, IR_Out[7:0], ALU_ZCNO[2:0]};

   always_ff @(posedge Clock) begin
      if (!Reset_n) state <= FETCH_L;
      else          state <= state_nxt;
   end

   always_comb begin
      MuxASel     = 2'b00;
      MuxBSel     = 2'b00;
      MuxCSel     = 1'b0;
      RF_OutASel  = 3'b000;
      RF_OutBSel  = 3'b000;
      RF_FunSel   = 2'b00;
      RF_RSel     = 4'b0000;
      RF_TSel     = 4'b0000;
      ALU_FunSel  = 4'b0000;
      ARF_OutASel = 2'b00;
      ARF_OutBSel = 2'b00;
      ARF_FunSel  = 2'b00;
      ARF_RSel    = 4'b0000;
      IR_Funsel   = 2'b00;
      IR_Enable   = 1'b0;
      IR_LH       = 1'b0;
      Mem_WR      = 1'b0;
      Mem_CS      = 1'b1;
      Halted      = 1'b0;
      Illegal     = 1'b0;
      state_nxt   = state;

      if (!Reset_n) begin
         // Reset only clears the PC; an in-flight instruction never commits.
         ARF_RSel   = PC_SEL;
         ARF_FunSel = FUN_CLR;
         state_nxt  = FETCH_L;
      end else begin
         case (state)
            FETCH_L, FETCH_H: begin
               ARF_OutBSel = 2'b00;
               Mem_CS      = 1'b0;
               IR_Enable   = 1'b1;
               IR_Funsel   = FUN_LOAD;
               IR_LH       = (state == FETCH_H);
               ARF_RSel    = PC_SEL;
               ARF_FunSel  = FUN_INC;
               state_nxt   = (state == FETCH_L) ? FETCH_H : EXEC;
            end
            EXEC: begin
               state_nxt = FETCH_L;
               case (opcode)
                  4'h0: ;
                  4'h1: begin
                     MuxASel   = 2'b10;
                     RF_FunSel = FUN_LOAD;
                     RF_RSel   = 4'b1000 >> rd;
                  end
                  4'h2, 4'h3: begin
                     RF_OutASel = {1'b1, rd};
                     RF_OutBSel = {1'b1, rs};
                     ALU_FunSel = (opcode == 4'h2) ? 4'b0100 : 4'b0101;
                     RF_FunSel  = FUN_LOAD;
                     RF_RSel    = 4'b1000 >> rd;
                  end
                  4'h4: begin
                     RF_OutBSel = {1'b1, rs};
                     ALU_FunSel = 4'b0001;
                     RF_FunSel  = FUN_LOAD;
                     RF_RSel    = 4'b1000 >> rd;
                  end
                  4'h5, 4'h6: begin
                     if (opcode == 4'h5 || flag_z) begin
                        MuxBSel    = 2'b10;
                        ARF_FunSel = FUN_LOAD;
                        ARF_RSel   = PC_SEL;
                     end
                  end
                  4'h7:    state_nxt = HALT;
                  default: Illegal   = 1'b1;
               endcase
            end
            HALT: Halted = 1'b1;
            default: state_nxt = FETCH_L;
         endcase
      end
   end

endmodule
